store_buffer_m: RTL and testbench

STORE_BUFFER_M -- requirements
Module: store_buffer_m

---
 rtl/store_buffer_m.sv | 120 ++++++++++++
 tb/tb_store_buffer_m.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_m.sv
// ---------------------------------------------------------------------------
// store_buffer_m
//   Word store buffer between the pipeline and data memory. Stores are held in
//   a circular FIFO and drained oldest-first. Loads can read forwarded data
//   from the youngest pending store to the same word address.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   storeValid/Addr/Data  store request from the pipeline
//   storeReady            buffer has room (count < DEPTH)
//   loadValid/Addr        load lookup
//   fwdHit/fwdData        forwarding result (combinational)
//   memWrite/Addr/Data    drain request for the head entry
//   memAck                memory accepted the drain
//   bufEmpty, count       occupancy status
// ---------------------------------------------------------------------------
module store_buffer_m #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        storeValid,
    input  logic [31:0] storeAddr,
    input  logic [31:0] storeData,
    output logic        storeReady,
    input  logic        loadValid,
    input  logic [31:0] loadAddr,
    output logic        fwdHit,
    output logic [31:0] fwdData,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memData,
    input  logic        memAck,
    output logic        bufEmpty,
    output logic [4:0]  count
);

    localparam int          PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  FULL = 5'(DEPTH);

    logic [29:0]    r_addr [DEPTH];
    logic [31:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [4:0]     r_count;

    logic           w_enq;
    logic           w_deq;
    logic           w_hit;
    logic [31:0]    w_fdata;
    logic [PW-1:0]  w_idx;

    // Ready depends only on registered occupancy: a full buffer that is
    // draining this cycle still refuses the store.
    assign storeReady = (r_count < FULL);
    assign memWrite   = (r_count != 5'd0);
    assign bufEmpty   = (r_count == 5'd0);
    assign count      = r_count;
    assign memAddr    = memWrite ? {r_addr[r_head], 2'b00} : 32'd0;
    assign memData    = memWrite ? r_data[r_head] : 32'd0;

    assign w_enq = storeValid && storeReady;
    assign w_deq = memWrite && memAck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 5'd0;
            r_valid <= '0;
        end else begin
            // head and tail only coincide when empty or full, and neither
            // case allows both an enqueue and a dequeue, so the two valid
            // updates never hit the same slot.
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= storeAddr[31:2];
            r_data[r_tail] <= storeData;
        end
    end

    // Walk pending entries oldest to youngest; the last match wins, which
    // gives youngest-match priority. Only registered entries are searched,
    // so a store arriving this cycle is never forwarded.
    always_comb begin
        w_hit   = 1'b0;
        w_fdata = 32'd0;
        w_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if ((5'(i) < r_count) && r_valid[w_idx] &&
                (r_addr[w_idx] == loadAddr[31:2])) begin
                w_hit   = 1'b1;
                w_fdata = r_data[w_idx];
            end
        end
    end

    assign fwdHit  = loadValid && w_hit;
    assign fwdData = fwdHit ? w_fdata : 32'd0;

endmodule

// File: tb/tb_store_buffer_m.sv
module tb_store_buffer_m;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        storeValid;
    logic [31:0] storeAddr;
    logic [31:0] storeData;
    logic        storeReady;
    logic        loadValid;
    logic [31:0] loadAddr;
    logic        fwdHit;
    logic [31:0] fwdData;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        memAck;
    logic        bufEmpty;
    logic [4:0]  count;

    int nvec = 0;
    int nerr = 0;

    store_buffer_m #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .storeValid(storeValid), .storeAddr(storeAddr), .storeData(storeData),
        .storeReady(storeReady),
        .loadValid(loadValid), .loadAddr(loadAddr),
        .fwdHit(fwdHit), .fwdData(fwdData),
        .memWrite(memWrite), .memAddr(memAddr), .memData(memData),
        .memAck(memAck), .bufEmpty(bufEmpty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, land 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d);
        storeValid = 1'b1;
        storeAddr  = a;
        storeData  = d;
    endtask

    initial begin
        // model state for the wrap-around segment
        logic [31:0] q_addr[$];
        int          mcnt;
        int          sent;
        logic        m_enq;
        logic        m_deq;

        rst_n = 1'b0; storeValid = 1'b0; storeAddr = '0; storeData = '0;
        loadValid = 1'b0; loadAddr = '0; memAck = 1'b0;
        #2;
        chk("rst_storeReady", 32'(storeReady), 32'd1);
        chk("rst_memWrite",   32'(memWrite),   32'd0);
        chk("rst_memAddr",    memAddr,         32'd0);
        chk("rst_memData",    memData,         32'd0);
        chk("rst_fwdHit",     32'(fwdHit),     32'd0);
        chk("rst_fwdData",    fwdData,         32'd0);
        chk("rst_bufEmpty",   32'(bufEmpty),   32'd1);
        chk("rst_count",      32'(count),      32'd0);
        step();
        rst_n = 1'b1;
        step();

        // single store, latency 1
        put(32'h0000_0104, 32'hDEAD_BEEF);
        memAck = 1'b1;
        #1;
        chk("s_memWrite_pre", 32'(memWrite), 32'd0);
        step();
        storeValid = 1'b0;
        #1;
        chk("s_memWrite", 32'(memWrite), 32'd1);
        chk("s_memAddr",  memAddr,       32'h0000_0104);
        chk("s_memData",  memData,       32'hDEAD_BEEF);
        step();
        chk("s_bufEmpty", 32'(bufEmpty), 32'd1);
        chk("s_count0",   32'(count),    32'd0);

        // fill, fifth store dropped, then ordered drain
        memAck = 1'b0;
        put(32'h10, 32'h110); step();
        put(32'h14, 32'h114); step();
        put(32'h18, 32'h118); step();
        put(32'h1C, 32'h11C); step();
        chk("f_count4",     32'(count),      32'd4);
        chk("f_storeReady", 32'(storeReady), 32'd0);
        put(32'h20, 32'h120); step();
        chk("f_count_drop", 32'(count),      32'd4);
        storeValid = 1'b0;
        memAck     = 1'b1;
        #1;
        chk("f_d0_addr", memAddr, 32'h10); chk("f_d0_data", memData, 32'h110); step();
        chk("f_d1_addr", memAddr, 32'h14); chk("f_d1_data", memData, 32'h114); step();
        chk("f_d2_addr", memAddr, 32'h18); chk("f_d2_data", memData, 32'h118); step();
        chk("f_d3_addr", memAddr, 32'h1C); chk("f_d3_data", memData, 32'h11C); step();
        chk("f_empty", 32'(bufEmpty), 32'd1);

        // forwarding priority
        memAck = 1'b0;
        put(32'h40, 32'h1); step();
        put(32'h44, 32'h2); step();
        put(32'h40, 32'h3); step();
        storeValid = 1'b0;
        loadValid  = 1'b1; loadAddr = 32'h42; #1;
        chk("fw_hit_42",  32'(fwdHit), 32'd1);
        chk("fw_data_42", fwdData,     32'h3);
        loadAddr = 32'h44; #1;
        chk("fw_data_44", fwdData,     32'h2);
        loadAddr = 32'h48; #1;
        chk("fw_hit_48",  32'(fwdHit), 32'd0);
        chk("fw_data_48", fwdData,     32'h0);
        loadValid = 1'b0; loadAddr = 32'h40; #1;
        chk("fw_noload_hit",  32'(fwdHit), 32'd0);
        chk("fw_noload_data", fwdData,     32'h0);
        // store to 0x48 in the same cycle as a load from 0x48: not forwarded
        put(32'h48, 32'h9);
        loadValid = 1'b1; loadAddr = 32'h48; #1;
        chk("fw_sameCycle_hit", 32'(fwdHit), 32'd0);
        step();
        storeValid = 1'b0; #1;
        chk("fw_after_hit",  32'(fwdHit), 32'd1);
        chk("fw_after_data", fwdData,     32'h9);
        chk("fw_count4",     32'(count),  32'd4);

        // simultaneous enqueue/dequeue at full and below full
        put(32'h50, 32'h5);
        memAck = 1'b1;
        loadAddr = 32'h44; #1;
        chk("sim_ready_full", 32'(storeReady), 32'd0);
        step();
        chk("sim_count3", 32'(count),   32'd3);
        chk("sim_head44", memAddr,      32'h44);
        // head 0x44 is being dequeued this cycle and still forwards
        chk("sim_fwd_head_hit",  32'(fwdHit), 32'd1);
        chk("sim_fwd_head_data", fwdData,     32'h2);
        chk("sim_ready", 32'(storeReady), 32'd1);
        step();
        chk("sim_count_keep", 32'(count), 32'd3);
        storeValid = 1'b0; loadValid = 1'b0; #1;
        chk("sim_d0_addr", memAddr, 32'h40); chk("sim_d0_data", memData, 32'h3); step();
        chk("sim_d1_addr", memAddr, 32'h48); chk("sim_d1_data", memData, 32'h9); step();
        chk("sim_d2_addr", memAddr, 32'h50); chk("sim_d2_data", memData, 32'h5); step();
        chk("sim_empty", 32'(bufEmpty), 32'd1);

        // wrap-around: 10 stores with memAck toggling, upstream holds when not ready
        mcnt = 0; sent = 0;
        for (int c = 0; c < 40; c++) begin
            storeValid = (sent < 10);
            storeAddr  = 32'h200 + 32'(sent) * 4;
            storeData  = 32'hA000 + 32'(sent);
            memAck     = c[0];
            #1;
            if (mcnt != 0) begin
                chk("wr_memAddr", memAddr, q_addr[0]);
            end
            chk("wr_count", 32'(count), 32'(mcnt));
            m_enq = storeValid && (mcnt < 4);
            m_deq = (mcnt != 0) && memAck;
            step();
            if (m_deq) begin
                void'(q_addr.pop_front());
                mcnt--;
            end
            if (m_enq) begin
                q_addr.push_back(32'h200 + 32'(sent) * 4);
                mcnt++;
                sent++;
            end
        end
        storeValid = 1'b0; memAck = 1'b0;
        chk("wr_all_sent", 32'(sent), 32'd10);
        chk("wr_empty", 32'(bufEmpty), 32'd1);

        // reset mid-operation
        put(32'h300, 32'h1); step();
        put(32'h304, 32'h2); step();
        put(32'h308, 32'h3); step();
        storeValid = 1'b0;
        chk("rm_count3", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_memWrite",   32'(memWrite),   32'd0);
        chk("rm_count",      32'(count),      32'd0);
        chk("rm_storeReady", 32'(storeReady), 32'd1);
        chk("rm_bufEmpty",   32'(bufEmpty),   32'd1);
        #1;
        rst_n  = 1'b1;
        memAck = 1'b1;
        step();
        chk("rm_post_memWrite", 32'(memWrite), 32'd0);
        step();
        chk("rm_post_memAddr", memAddr, 32'd0);
        chk("rm_post_count",   32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // hard bound so the run always ends
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
